// File: rtl/instr_fetch.sv
// Fetch stage: pulls 1-3 byte instructions from byte-wide program memory
// and hands each complete instruction to the decoder over valid/ready.
module instr_fetch #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_enable,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_op1,
  output logic [DATA_W-1:0] instr_op2,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic {
    FETCH,
    HOLD
  } state_t;

  state_t     state;
  logic [1:0] byte_idx;
  logic [1:0] rdata_len;
  logic [1:0] cur_len;
  logic       last_byte;

  always_comb begin
    rdata_len = 2'd1;
    unique case (1'b1)
      (mem_rdata[7:6] == 2'b01): rdata_len = 2'd2;
      (mem_rdata[7:6] == 2'b10): rdata_len = 2'd3;
      default:                   rdata_len = 2'd1;
    endcase
  end

  // Byte 0 must use the length of the opcode arriving now, not the
  // length latched for the previous instruction.
  assign cur_len   = (byte_idx == 2'd0) ? rdata_len : instr_len;
  assign last_byte = (byte_idx + 2'd1) == cur_len;

  assign mem_req   = (state == FETCH) && !flush && !reset;
  assign mem_addr  = pc;
  assign pc_enable = mem_req && mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      byte_idx     <= 2'd0;
      instr_valid  <= 1'b0;
      instr_opcode <= '0;
      instr_op1    <= '0;
      instr_op2    <= '0;
      instr_len    <= 2'd0;
      instr_pc     <= '0;
    end else if (flush) begin
      state       <= FETCH;
      byte_idx    <= 2'd0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (pc_enable) begin
            unique case (byte_idx)
              2'd0: begin
                instr_opcode <= mem_rdata;
                instr_pc     <= pc;
                instr_op1    <= '0;
                instr_op2    <= '0;
                instr_len    <= rdata_len;
              end
              2'd1:    instr_op1 <= mem_rdata;
              default: instr_op2 <= mem_rdata;
            endcase
            if (last_byte) begin
              state       <= HOLD;
              instr_valid <= 1'b1;
              byte_idx    <= 2'd0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state       <= FETCH;
            instr_valid <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a byte-counting model
// that also plays program_counter and program memory.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pc;
  logic        pc_enable;
  logic        flush;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_op1;
  logic [7:0]  instr_op2;
  logic [1:0]  instr_len;
  logic [11:0] instr_pc;

  instr_fetch #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .pc_enable    (pc_enable),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_op1    (instr_op1),
    .instr_op2    (instr_op2),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [4096];
  logic [11:0] pc_nxt;
  logic [11:0] start;
  int          cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic int dec(input logic [7:0] op);
    if (op[7:6] == 2'b01) return 2;
    if (op[7:6] == 2'b10) return 3;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc     = 12'h000;
    pc_nxt = 12'h000;
    start  = 12'h000;
    cnt    = 0;
  endtask

  // One clock: drive at negedge, compare just before posedge, then
  // advance the model and the emulated program counter.
  task automatic cycle(input bit ack, input bit rdy, input bit fl,
                       input logic [11:0] tgt);
    int  elen;
    bit  ev, ereq, een;
    @(negedge clk);
    pc          = pc_nxt;
    mem_ack     = ack;
    instr_ready = rdy;
    flush       = fl;
    mem_rdata   = ack ? mem[pc] : 8'($urandom);
    #3;
    elen = dec(mem[start]);
    ev   = (cnt != 0) && (cnt == elen);
    ereq = !ev && !fl;
    een  = ereq && ack;
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    chk("mem_req", 32'(mem_req), 32'(ereq));
    chk("pc_enable", 32'(pc_enable), 32'(een));
    chk("mem_addr", 32'(mem_addr), 32'(pc));
    if (ev) begin
      chk("opcode", 32'(instr_opcode), 32'(mem[start]));
      chk("op1", 32'(instr_op1),
          elen >= 2 ? 32'(mem[12'(start + 1)]) : 32'h0);
      chk("op2", 32'(instr_op2),
          elen >= 3 ? 32'(mem[12'(start + 2)]) : 32'h0);
      chk("len", 32'(instr_len), 32'(elen));
      chk("instr_pc", 32'(instr_pc), 32'(start));
    end
    pc_nxt = pc_enable ? 12'(pc + 1) : pc;
    if (fl) begin
      start  = tgt;
      cnt    = 0;
      pc_nxt = tgt;
    end else if (ev && rdy) begin
      start = 12'(start + 12'(elen));
      cnt   = 0;
    end else if (een) begin
      cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'h05;
    mem[12'h010] = 8'h80;
    mem[12'h011] = 8'hAA;
    mem[12'h012] = 8'hBB;
    mem[12'h013] = 8'h41;
    mem[12'h014] = 8'h22;
    mem[12'h015] = 8'h80;
    mem[12'h200] = 8'h05;
    reset       = 1'b1;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    instr_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_opcode", 32'(instr_opcode), 32'h0);
    chk("rst_len", 32'(instr_len), 32'h0);
    chk("rst_pc", 32'(instr_pc), 32'h0);
    reset = 1'b0;

    // 1-byte at 000, then backpressure
    cycle(1, 0, 0, 0);
    chk("lit_en_1b", 32'(pc_enable), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      chk("lit_hold_valid", 32'(instr_valid), 32'h1);
      chk("lit_hold_en", 32'(pc_enable), 32'h0);
    end
    chk("lit_op_05", 32'(instr_opcode), 32'h05);
    chk("lit_len_1", 32'(instr_len), 32'h1);
    chk("lit_pc_000", 32'(instr_pc), 32'h000);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 12'h010);
    chk("lit_flush_en", 32'(pc_enable), 32'h0);

    // 3-byte at 010
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0);
      chk("lit_en_3b", 32'(pc_enable), 32'h1);
    end
    cycle(1, 0, 0, 0);
    chk("lit_op_80", 32'(instr_opcode), 32'h80);
    chk("lit_op1_aa", 32'(instr_op1), 32'hAA);
    chk("lit_op2_bb", 32'(instr_op2), 32'hBB);
    chk("lit_len_3", 32'(instr_len), 32'h3);
    chk("lit_pc_010", 32'(instr_pc), 32'h010);
    chk("lit_pc_013", 32'(pc), 32'h013);
    cycle(1, 1, 0, 0);

    // 2-byte with two wait states per byte
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 2; w++) begin
        cycle(0, 0, 0, 0);
        chk("lit_wait_req", 32'(mem_req), 32'h1);
        chk("lit_wait_en", 32'(pc_enable), 32'h0);
      end
      cycle(1, 0, 0, 0);
      chk("lit_ack_en", 32'(pc_enable), 32'h1);
    end
    cycle(0, 0, 0, 0);
    chk("lit_op1_22", 32'(instr_op1), 32'h22);
    chk("lit_len_2", 32'(instr_len), 32'h2);
    cycle(0, 1, 0, 0);

    // flush after byte 1 of a 3-byte instr
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 12'h200);
    chk("lit_fl_req", 32'(mem_req), 32'h0);
    chk("lit_fl_en", 32'(pc_enable), 32'h0);
    cycle(1, 0, 0, 0);
    chk("lit_post_fl_valid", 32'(instr_valid), 32'h0);
    cycle(0, 0, 0, 0);
    chk("lit_pc_200", 32'(instr_pc), 32'h200);

    // async reset while holding
    #1 reset = 1'b1;
    #1 chk("lit_async_valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1, 0, 0, 0);
    chk("lit_restart_addr", 32'(mem_addr), 32'h000);
    cycle(0, 1, 0, 0);
    chk("lit_restart_pc", 32'(instr_pc), 32'h000);

    // random program and traffic
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(0, 0, 1, 12'hFF8);
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            $urandom_range(0, 24) == 0, 12'($urandom));
    end
    for (int i = 0; i < 500; i++)
      cycle(1, $urandom_range(0, 3) != 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
